regfile_fwd: RTL and testbench
==============================

# regfile_fwd

32×32-bit general-purpose register file with integrated operand forwarding and load-use stall detection. It sits between the decode stage and the write-back path. It receives results from the execute stage's result bus (`wd`/`wreg`/`wdata`), from the memory stage, and from the write-back port. It supplies the two source operands to decode, and it raises a stall request when an operand depends on a load still in execute.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers.
- `REG_W`, 32: register data width.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high (`RstEnable` = 1'b1).
- `we`  in  1: write-back write enable.
- `waddr`  in  5: write-back destination.
- `wdata`  in  32: write-back data.
- `ex_wreg`  in  1: execute-stage result valid for write.
- `ex_wd`  in  5: execute-stage destination.
- `ex_wdata`  in  32: execute-stage result.
- `ex_is_load`  in  1: execute-stage instruction is a load, so its data is not yet available.
- `mem_wreg`  in  1: memory-stage write valid.
- `mem_wd`  in  5: memory-stage destination.
- `mem_wdata`  in  32: memory-stage result.
- `re1`, `re2`  in  1 each: read-port enables.
- `raddr1`, `raddr2`  in  5 each: read-port addresses.
- `rdata1`, `rdata2`  out  32 each: operand values. Combinational.
- `stallreq`  out  1: stall decode/fetch this cycle. Combinational.
- `wr_count`  out  32: count of committed architectural writes. Registered.

## Operation
- Storage is an array of `REG_NUM` words. Entry 0 is hard-wired to zero.
- Writes:
  - When `we`=1 and `waddr`≠0, `wdata` is stored at the rising edge and `wr_count` increments by 1.
  - Writes with `waddr`=0 are dropped and not counted.
- Read resolution per port, first match wins:
  1. `rst`=1 → `ZeroWord`.
  2. `re`=0 → `ZeroWord`.
  3. `raddr`=0 → `ZeroWord`.
  4. `ex_wreg`=1 and `ex_wd`=`raddr` → `ex_wdata`.
  5. `mem_wreg`=1 and `mem_wd`=`raddr` → `mem_wdata`.
  6. `we`=1 and `waddr`=`raddr` → `wdata` (same-cycle write bypass).
  7. Otherwise → the array entry.
- Load-use detection:
  - `stallreq`=1 when `ex_is_load`=1, `ex_wreg`=1, `ex_wd`≠0, and, for either port, `re`=1 with `raddr`=`ex_wd`.
  - While stalled, `rdata` still follows the priority list above. Decode discards the value.
  - `ex_is_load` with `ex_wreg`=0 never stalls.
- `wr_count` wraps from 0xFFFFFFFF to 0 with no sticky flag.

## Timing
- Reset:
  - All array entries clear to 0 on the first rising edge with `rst`=1.
  - `wr_count` clears to 0 on that edge.
  - `rdata1`, `rdata2` and `stallreq` are 0 combinationally for as long as `rst`=1.
  - A write presented during reset is discarded.
- Write latency: 1 edge into the array. Through the bypass path the value is visible on `rdata` in the same cycle.
- Read latency: 0 cycles (combinational from address and forwarding inputs).
- `stallreq` has 0-cycle latency and is deasserted in the cycle after the load leaves execute. In that cycle the load is in memory and is forwarded via `mem_wdata`.
- Simultaneous hits: if execute, memory and write-back all target the same register, execute wins (youngest producer).
- If `rst` is asserted mid-stream, it overrides any in-flight write in that cycle.

## Structure
- Shared package / defines holds:
  - `RegBus` [31:0], `RegAddrBus` [4:0], `RegNum` 32.
  - `ZeroWord`.
  - `RstEnable`, `WriteEnable`, `ReadEnable`, `ChipEnable`.
  - `NOPRegAddr` 5'b00000.
- One sub-module is natural: `fwd_mux`, instantiated twice, one per read port. It contains the priority resolution (steps 1–7) plus that port's load-hit flag. The top level ORs the two hit flags into `stallreq` and owns the array and `wr_count`.

## Test plan
- Reset clear:
  - Hold `rst`=1 for 1 edge.
  - Read every address with `re`=1 → all return 0; `wr_count`=0.
  - During reset, `we`=1, `waddr`=5, `wdata`=0xDEADBEEF → r5 still reads 0 after reset.
- Write/read and $0:
  - Write r3=0x12345678 → next cycle `raddr1`=3 gives 0x12345678.
  - Write r0=0xFFFFFFFF → `raddr2`=0 gives 0 and `wr_count` is unchanged.
- Same-cycle bypass: `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5 with `raddr1`=7 and no execute/memory hits → `rdata1`=0xA5A5A5A5 in that cycle.
- Priority:
  - Set execute, memory and write-back all targeting r9 with data 0x1, 0x2, 0x3 → `rdata1`=0x1.
  - Drop `ex_wreg` → 0x2.
  - Drop `mem_wreg` → 0x3.
- Load-use:
  - `ex_is_load`=1, `ex_wreg`=1, `ex_wd`=4, `re2`=1, `raddr2`=4 → `stallreq`=1.
  - Same with `raddr2`=0 → `stallreq`=0.
  - Next cycle, load moves to memory (`mem_wd`=4, `mem_wdata`=0x55) → `stallreq`=0, `rdata2`=0x55.
- Counter wrap: preload `wr_count` to 0xFFFFFFFE via the bench force path, then perform 2 non-zero writes → `wr_count`=0x00000000.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared types and constants for the forwarding register file.
package regfile_fwd_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam int        RegNum      = 32;
    localparam RegBus     ZeroWord    = 32'h0000_0000;
    localparam logic      RstEnable   = 1'b1;
    localparam logic      WriteEnable = 1'b1;
    localparam logic      ReadEnable  = 1'b1;
    localparam logic      ChipEnable  = 1'b1;
    localparam RegAddrBus NOPRegAddr  = 5'b00000;

    // True when a producer is valid and targets the register being read.
    function automatic logic addr_hit(input logic valid, input RegAddrBus dst,
                                      input RegAddrBus src);
        return (valid == WriteEnable) && (dst == src);
    endfunction

endpackage

// File: rtl/regfile_fwd_if.sv
// Decode/pipeline-side bundle of the register file: write-back, execute and
// memory producers, two read ports, stall request and the write counter.
interface regfile_fwd_if;
    import regfile_fwd_pkg::*;

    logic      we;
    RegAddrBus waddr;
    RegBus     wdata;

    logic      ex_wreg;
    RegAddrBus ex_wd;
    RegBus     ex_wdata;
    logic      ex_is_load;

    logic      mem_wreg;
    RegAddrBus mem_wd;
    RegBus     mem_wdata;

    logic      re1;
    logic      re2;
    RegAddrBus raddr1;
    RegAddrBus raddr2;
    RegBus     rdata1;
    RegBus     rdata2;

    logic      stallreq;
    RegBus     wr_count;

    modport master (
        output we, waddr, wdata,
        output ex_wreg, ex_wd, ex_wdata, ex_is_load,
        output mem_wreg, mem_wd, mem_wdata,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, stallreq, wr_count
    );

    modport slave (
        input  we, waddr, wdata,
        input  ex_wreg, ex_wd, ex_wdata, ex_is_load,
        input  mem_wreg, mem_wd, mem_wdata,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, stallreq, wr_count
    );

endinterface

// File: rtl/regfile_fwd_fwd_mux.sv
// One read port: picks the youngest producer of the requested register and
// flags when that producer is a load whose data does not exist yet.
module fwd_mux
    import regfile_fwd_pkg::*;
#(
    parameter int REG_W = 32
) (
    input  logic             rst,
    input  logic             re,
    input  RegAddrBus        raddr,
    input  logic             ex_wreg,
    input  RegAddrBus        ex_wd,
    input  logic [REG_W-1:0] ex_wdata,
    input  logic             ex_is_load,
    input  logic             mem_wreg,
    input  RegAddrBus        mem_wd,
    input  logic [REG_W-1:0] mem_wdata,
    input  logic             we,
    input  RegAddrBus        waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [REG_W-1:0] array_data,
    output logic [REG_W-1:0] rdata,
    output logic             load_hit
);

    localparam logic [REG_W-1:0] Zero = REG_W'(ZeroWord);

    // Priority chain: reset, disabled port and $0 read as zero, then
    // execute beats memory beats write-back beats the stored value.
    always_comb begin
        rdata = Zero;
        if (rst == RstEnable) begin
            rdata = Zero;
        end else if (re != ReadEnable) begin
            rdata = Zero;
        end else if (raddr == NOPRegAddr) begin
            rdata = Zero;
        end else if (addr_hit(ex_wreg, ex_wd, raddr)) begin
            rdata = ex_wdata;
        end else if (addr_hit(mem_wreg, mem_wd, raddr)) begin
            rdata = mem_wdata;
        end else if (addr_hit(we, waddr, raddr)) begin
            rdata = wdata;
        end else begin
            rdata = array_data;
        end
    end

    // A load still in execute that this port depends on cannot be bypassed.
    always_comb begin
        load_hit = 1'b0;
        if (rst != RstEnable && re == ReadEnable && ex_is_load &&
            ex_wd != NOPRegAddr && addr_hit(ex_wreg, ex_wd, raddr)) begin
            load_hit = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 register file with execute/memory/write-back forwarding, load-use
// stall detection and a count of committed writes.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int REG_NUM = RegNum,
    parameter int REG_W   = 32
) (
    input logic               clk,
    input logic               rst,
    regfile_fwd_if.slave      bus
);

    logic [REG_W-1:0] regs [REG_NUM];
    RegBus            wr_count_q;
    logic             hit1;
    logic             hit2;

    // Commit write-back data; $0 writes are dropped and reset wins over any write.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            wr_count_q <= ZeroWord;
        end else if (bus.we == WriteEnable && bus.waddr != NOPRegAddr) begin
            regs[bus.waddr] <= bus.wdata;
            wr_count_q      <= wr_count_q + 32'd1;
        end
    end

    fwd_mux #(.REG_W(REG_W)) u_port1 (
        .rst        (rst),
        .re         (bus.re1),
        .raddr      (bus.raddr1),
        .ex_wreg    (bus.ex_wreg),
        .ex_wd      (bus.ex_wd),
        .ex_wdata   (bus.ex_wdata),
        .ex_is_load (bus.ex_is_load),
        .mem_wreg   (bus.mem_wreg),
        .mem_wd     (bus.mem_wd),
        .mem_wdata  (bus.mem_wdata),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .wdata      (bus.wdata),
        .array_data (regs[bus.raddr1]),
        .rdata      (bus.rdata1),
        .load_hit   (hit1)
    );

    fwd_mux #(.REG_W(REG_W)) u_port2 (
        .rst        (rst),
        .re         (bus.re2),
        .raddr      (bus.raddr2),
        .ex_wreg    (bus.ex_wreg),
        .ex_wd      (bus.ex_wd),
        .ex_wdata   (bus.ex_wdata),
        .ex_is_load (bus.ex_is_load),
        .mem_wreg   (bus.mem_wreg),
        .mem_wd     (bus.mem_wd),
        .mem_wdata  (bus.mem_wdata),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .wdata      (bus.wdata),
        .array_data (regs[bus.raddr2]),
        .rdata      (bus.rdata2),
        .load_hit   (hit2)
    );

    assign bus.stallreq = hit1 | hit2;
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_fwd.sv
// Randomized and directed bench for regfile_fwd against a behavioural model.
module tb_regfile_fwd;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_fwd_if bus_if ();

    regfile_fwd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    bit          check_en     = 1'b0;
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    // Architectural state as the pipeline sees it after each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
            model_count = 32'h0;
        end else if (bus_if.we && bus_if.waddr != 5'd0) begin
            model_regs[bus_if.waddr] = bus_if.wdata;
            model_count = model_count + 32'd1;
        end
    end

    // Youngest producer of a register, or the committed value.
    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'h0;
        if (bus_if.ex_wreg && bus_if.ex_wd == a) return bus_if.ex_wdata;
        if (bus_if.mem_wreg && bus_if.mem_wd == a) return bus_if.mem_wdata;
        if (bus_if.we && bus_if.waddr == a) return bus_if.wdata;
        return model_regs[a];
    endfunction

    function automatic logic model_stall();
        logic dep;
        dep = (bus_if.re1 && bus_if.raddr1 == bus_if.ex_wd) ||
              (bus_if.re2 && bus_if.raddr2 == bus_if.ex_wd);
        return !rst && bus_if.ex_is_load && bus_if.ex_wreg &&
               bus_if.ex_wd != 5'd0 && dep;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge once reset has been applied, outputs must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("model_rdata1", bus_if.rdata1, model_read(bus_if.re1, bus_if.raddr1));
            check_output("model_rdata2", bus_if.rdata2, model_read(bus_if.re2, bus_if.raddr2));
            check_output("model_stall", {31'd0, bus_if.stallreq}, {31'd0, model_stall()});
            check_output("model_wr_count", bus_if.wr_count, model_count);
        end
    end

    task automatic idle_inputs();
        bus_if.we = 0;         bus_if.waddr = 0;     bus_if.wdata = 0;
        bus_if.ex_wreg = 0;    bus_if.ex_wd = 0;     bus_if.ex_wdata = 0;
        bus_if.ex_is_load = 0;
        bus_if.mem_wreg = 0;   bus_if.mem_wd = 0;    bus_if.mem_wdata = 0;
        bus_if.re1 = 0;        bus_if.re2 = 0;
        bus_if.raddr1 = 0;     bus_if.raddr2 = 0;
    endtask

    // Advance one edge and return all pipeline inputs to idle.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_producers(input logic ex_v, input logic mem_v, input logic wb_v);
        bus_if.ex_wreg  = ex_v;  bus_if.ex_wd  = 5'd9; bus_if.ex_wdata  = 32'h1;
        bus_if.mem_wreg = mem_v; bus_if.mem_wd = 5'd9; bus_if.mem_wdata = 32'h2;
        bus_if.we       = wb_v;  bus_if.waddr  = 5'd9; bus_if.wdata     = 32'h3;
        bus_if.re1 = 1; bus_if.raddr1 = 5'd9;
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        idle_inputs();
        rst = 1'b1;
        bus_if.we = 1; bus_if.waddr = 5'd5; bus_if.wdata = 32'hDEADBEEF;
        bus_if.re1 = 1; bus_if.raddr1 = 5'd5;
        bus_if.ex_wreg = 1; bus_if.ex_wd = 5'd5; bus_if.ex_is_load = 1;
        bus_if.re2 = 1; bus_if.raddr2 = 5'd5; bus_if.ex_wdata = 32'h77;
        #2;
        check_output("rst_rdata1", bus_if.rdata1, 32'h0);
        check_output("rst_rdata2", bus_if.rdata2, 32'h0);
        check_output("rst_stall", {31'd0, bus_if.stallreq}, 32'h0);
        @(posedge clk);
        check_en = 1'b1;
        #1;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            bus_if.re1 = 1; bus_if.raddr1 = 5'(i);
            bus_if.re2 = 1; bus_if.raddr2 = 5'(31 - i);
            @(negedge clk);
            check_output("clear_rdata1", bus_if.rdata1, 32'h0);
            check_output("clear_rdata2", bus_if.rdata2, 32'h0);
            if (i == 0) check_output("clear_wr_count", bus_if.wr_count, 32'h0);
            apply_stimulus();
        end

        bus_if.we = 1; bus_if.waddr = 5'd3; bus_if.wdata = 32'h12345678;
        @(negedge clk);
        apply_stimulus();
        bus_if.re1 = 1; bus_if.raddr1 = 5'd3;
        @(negedge clk);
        check_output("read_r3", bus_if.rdata1, 32'h12345678);
        check_output("count_after_r3", bus_if.wr_count, 32'h1);

        apply_stimulus();
        bus_if.we = 1; bus_if.waddr = 5'd0; bus_if.wdata = 32'hFFFFFFFF;
        bus_if.re2 = 1; bus_if.raddr2 = 5'd0;
        @(negedge clk);
        check_output("read_r0", bus_if.rdata2, 32'h0);
        apply_stimulus();
        bus_if.re2 = 1; bus_if.raddr2 = 5'd0;
        @(negedge clk);
        check_output("count_after_r0", bus_if.wr_count, 32'h1);

        apply_stimulus();
        bus_if.we = 1; bus_if.waddr = 5'd7; bus_if.wdata = 32'hA5A5A5A5;
        bus_if.re1 = 1; bus_if.raddr1 = 5'd7;
        @(negedge clk);
        check_output("bypass_r7", bus_if.rdata1, 32'hA5A5A5A5);

        apply_stimulus();
        set_producers(1, 1, 1);
        @(negedge clk);
        check_output("prio_ex", bus_if.rdata1, 32'h1);
        apply_stimulus();
        set_producers(0, 1, 1);
        @(negedge clk);
        check_output("prio_mem", bus_if.rdata1, 32'h2);
        apply_stimulus();
        set_producers(0, 0, 1);
        @(negedge clk);
        check_output("prio_wb", bus_if.rdata1, 32'h3);

        apply_stimulus();
        bus_if.ex_is_load = 1; bus_if.ex_wreg = 1; bus_if.ex_wd = 5'd4;
        bus_if.re2 = 1; bus_if.raddr2 = 5'd4;
        @(negedge clk);
        check_output("load_use_stall", {31'd0, bus_if.stallreq}, 32'h1);
        apply_stimulus();
        bus_if.ex_is_load = 1; bus_if.ex_wreg = 1; bus_if.ex_wd = 5'd4;
        bus_if.re2 = 1; bus_if.raddr2 = 5'd0;
        @(negedge clk);
        check_output("load_no_dep", {31'd0, bus_if.stallreq}, 32'h0);
        apply_stimulus();
        bus_if.mem_wreg = 1; bus_if.mem_wd = 5'd4; bus_if.mem_wdata = 32'h55;
        bus_if.re2 = 1; bus_if.raddr2 = 5'd4;
        @(negedge clk);
        check_output("load_in_mem_stall", {31'd0, bus_if.stallreq}, 32'h0);
        check_output("load_in_mem_data", bus_if.rdata2, 32'h55);
        apply_stimulus();
        bus_if.ex_is_load = 1; bus_if.ex_wreg = 0; bus_if.ex_wd = 5'd4;
        bus_if.re1 = 1; bus_if.raddr1 = 5'd4;
        @(negedge clk);
        check_output("load_no_wreg", {31'd0, bus_if.stallreq}, 32'h0);

        apply_stimulus();
        force dut.wr_count_q = 32'hFFFF_FFFE;
        model_count = 32'hFFFF_FFFE;
        #1;
        release dut.wr_count_q;
        @(negedge clk);
        apply_stimulus();
        bus_if.we = 1; bus_if.waddr = 5'd1; bus_if.wdata = $urandom;
        @(negedge clk);
        apply_stimulus();
        bus_if.we = 1; bus_if.waddr = 5'd2; bus_if.wdata = $urandom;
        @(negedge clk);
        apply_stimulus();
        @(negedge clk);
        check_output("count_wrap", bus_if.wr_count, 32'h0);

        repeat (600) begin
            apply_stimulus();
            rst = ($urandom_range(0, 40) == 0);
            bus_if.we         = $urandom_range(0, 1);
            bus_if.waddr      = 5'($urandom_range(0, 7));
            bus_if.wdata      = $urandom;
            bus_if.ex_wreg    = $urandom_range(0, 1);
            bus_if.ex_wd      = 5'($urandom_range(0, 7));
            bus_if.ex_wdata   = $urandom;
            bus_if.ex_is_load = $urandom_range(0, 1);
            bus_if.mem_wreg   = $urandom_range(0, 1);
            bus_if.mem_wd     = 5'($urandom_range(0, 7));
            bus_if.mem_wdata  = $urandom;
            bus_if.re1        = ($urandom_range(0, 3) != 0);
            bus_if.re2        = ($urandom_range(0, 3) != 0);
            bus_if.raddr1     = 5'($urandom_range(0, 7));
            bus_if.raddr2     = 5'($urandom_range(0, 7));
            @(negedge clk);
        end

        apply_stimulus();
        rst = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
